regbank_arbiter: RTL and testbench

- Owns the 64 x 16-bit register bank that the SPI slave reads and writes.
- Shares single-port access to the bank between NREQ requesters using round-robin arbitration, for example SPI slave and fabric logic.
- Exports the whole bank as a flat vector for combinational readout.
- Sequences every access through a fixed three-state handshake, so contention is deterministic and starvation-free.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/regbank_arbiter.sv | 152 +++++++++++++++
 tb/tb_regbank_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// regbank_pkg
// Shared constants and FSM state type for the register bank arbiter.
// REG_AW    : register address width (fixed at 6 bits)
// REG_DW    : default register data width
// REG_DEPTH : default number of registers in the bank
// state_e   : access handshake states, IDLE -> GRANT -> ACK -> IDLE
package regbank_pkg;

  localparam int REG_AW    = 6;
  localparam int REG_DW    = 16;
  localparam int REG_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. Starting just after the
// previous winner and wrapping modulo N, the first asserted request wins.
// Ports:
//   req    [N-1:0] in  : request vector
//   last   [2:0]   in  : index of the previous winner (must be < N)
//   valid          out : at least one request is asserted
//   winner [2:0]   out : index of the chosen requester (0 when !valid)
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic         valid,
  output logic [2:0]   winner
);

  // Walk the search order from the farthest candidate back to the nearest,
  // so the nearest asserted request is the last assignment and therefore wins.
  always_comb begin
    valid  = 1'b0;
    winner = 3'd0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// regbank_arbiter
// Owns a DEPTH x WIDTH register bank shared by NREQ requesters. Every access
// runs through IDLE -> GRANT -> ACK; the winner is chosen round-robin in IDLE
// and its request is latched, so later input changes cannot disturb it.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   req   [NREQ]     : per-requester request, held until ack
//   we    [NREQ]     : per-requester write enable (1 = write)
//   addr  [NREQ*6]   : per-requester address, slice i = [6*i+5:6*i]
//   wdata [NREQ*W]   : per-requester write data, slice i = [W*i+W-1:W*i]
//   ack   [NREQ]     : one-cycle completion pulse to the granted requester
//   err              : with ack, write hit a read-only register
//   rdata [W]        : with ack, register value before any write
//   busy             : high in GRANT and ACK
//   bank_data        : flat bank contents, register i at [W*i+W-1:W*i]
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int                NREQ      = 2,
  parameter int                DEPTH     = REG_DEPTH,
  parameter int                WIDTH     = REG_DW,
  parameter logic [DEPTH-1:0]  RO_MASK   = '0,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*REG_AW-1:0]   addr,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic [DEPTH*WIDTH-1:0]   bank_data
);

  localparam logic [2:0] LAST_INIT = 3'(NREQ - 1);

  state_e                state_q, state_d;
  logic [2:0]            lastGnt_q, gntIdx_q;
  logic                  we_q;
  logic [REG_AW-1:0]     addr_q;
  logic [WIDTH-1:0]      wdata_q, rdata_q;
  logic [NREQ-1:0]       ack_q;
  logic                  err_q;
  logic [WIDTH-1:0]      bank_q [DEPTH];

  logic                  arbValid;
  logic [2:0]            arbWinner;
  logic                  selWe;
  logic [REG_AW-1:0]     selAddr;
  logic [WIDTH-1:0]      selWdata;
  logic [NREQ-1:0]       grantVec;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req    (req),
    .last   (lastGnt_q),
    .valid  (arbValid),
    .winner (arbWinner)
  );

  // Mux out the winner's request fields; written as a compare loop so the
  // 3-bit winner index never has to be narrowed for small NREQ.
  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arbWinner == 3'(i)) begin
        selWe    = we[i];
        selAddr  = addr[REG_AW*i +: REG_AW];
        selWdata = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  // One-hot ack vector for the latched grant index.
  always_comb begin
    grantVec = '0;
    for (int i = 0; i < NREQ; i++) begin
      grantVec[i] = (gntIdx_q == 3'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arbValid) state_d = GRANT;
      GRANT:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath: latch the winner in IDLE, perform the access in GRANT so
  // ack/err/rdata appear in ACK, then drop the pulse on the way to IDLE.
  // Reset wipes any latched request, so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) bank_q[i] <= RESET_VAL;
      lastGnt_q <= LAST_INIT;
      gntIdx_q  <= 3'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          err_q <= 1'b0;
          if (arbValid) begin
            gntIdx_q  <= arbWinner;
            lastGnt_q <= arbWinner;
            we_q      <= selWe;
            addr_q    <= selAddr;
            wdata_q   <= selWdata;
          end
        end
        GRANT: begin
          rdata_q <= bank_q[addr_q];
          ack_q   <= grantVec;
          err_q   <= we_q && RO_MASK[addr_q];
          if (we_q && !RO_MASK[addr_q]) bank_q[addr_q] <= wdata_q;
        end
        default: begin
          ack_q <= '0;
          err_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bank_data = '0;
    for (int i = 0; i < DEPTH; i++) bank_data[WIDTH*i +: WIDTH] = bank_q[i];
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign busy  = (state_q == GRANT) || (state_q == ACK);

endmodule

// File: tb/tb_regbank_arbiter.sv
// tb_regbank_arbiter
// Self-checking bench for regbank_arbiter with two requesters and register 3
// read-only. A behavioural model (array of registers plus last-winner index)
// predicts every completion.
module tb_regbank_arbiter;

  localparam int          NREQ = 2;
  localparam logic [63:0] RO   = 64'h8;
  localparam logic [15:0] RV   = 16'h0000;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req, we;
  logic [NREQ*6-1:0] addr;
  logic [NREQ*16-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic              err;
  logic [15:0]       rdata;
  logic              busy;
  logic [64*16-1:0]  bank_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] mBank [64];
  int          mLast;

  regbank_arbiter #(
    .NREQ(NREQ), .DEPTH(64), .WIDTH(16), .RO_MASK(RO), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .bank_data(bank_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Model of the bank after reset.
  task automatic model_reset();
    for (int i = 0; i < 64; i++) mBank[i] = RV;
    mLast = NREQ - 1;
  endtask

  // Round-robin rule: first asserted request after the last winner, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] rq);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (mLast + k) % NREQ;
      if (rq[idx]) return idx;
    end
    return -1;
  endfunction

  // One access against the model: returns old value, applies writable writes.
  task automatic model_access(input bit w, input logic [5:0] a, input logic [15:0] d,
                              output logic e, output logic [15:0] rd);
    rd = mBank[a];
    e  = 1'b0;
    if (w) begin
      if (RO[a]) e = 1'b1;
      else       mBank[a] = d;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    req   = '0;
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one single-requester access from IDLE and waits (bounded) for ack.
  // lat counts clock edges from driving req to seeing ack; 0 means timeout.
  task automatic do_txn(input int r, input bit w, input logic [5:0] a, input logic [15:0] d,
                        output int lat, output logic [NREQ-1:0] ackSeen, output logic errSeen,
                        output logic [15:0] rdSeen, output logic [64*16-1:0] bankSeen);
    req = '0;
    req[r] = 1'b1;
    we[r]  = w;
    addr[6*r +: 6]   = a;
    wdata[16*r +: 16] = d;
    lat = 0; ackSeen = '0; errSeen = 1'b0; rdSeen = '0; bankSeen = '0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (ack != '0) begin
        lat = i; ackSeen = ack; errSeen = err; rdSeen = rdata; bankSeen = bank_data;
        break;
      end
    end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat; logic [NREQ-1:0] a; logic e; logic [15:0] rd; logic [64*16-1:0] b;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 00", ack); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    checks++; if (rdata !== 16'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (bank_data !== '0) begin errors++; $display("[TB] FAIL reset_bank: bank_data not all zero"); end
    rst_n = 1'b1;
    model_reset();
    do_txn(0, 1'b0, 6'd5, 16'h0, lat, a, e, rd, b);
    mLast = 0;
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL reset_read_latency: got %0d expected 2", lat); end
    checks++; if (a !== 2'b01) begin errors++; $display("[TB] FAIL reset_read_ack: got %b expected 01", a); end
    checks++; if (rd !== 16'h0) begin errors++; $display("[TB] FAIL reset_read_rdata: got %h expected 0000", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL reset_read_err: got %b expected 0", e); end
  endtask

  task automatic test_write_read();
    int lat; logic [NREQ-1:0] a; logic e, me; logic [15:0] rd, mrd; logic [64*16-1:0] b;
    model_access(1'b1, 6'd12, 16'hBEEF, me, mrd);
    do_txn(1, 1'b1, 6'd12, 16'hBEEF, lat, a, e, rd, b);
    mLast = 1;
    checks++; if (a !== 2'b10) begin errors++; $display("[TB] FAIL wr_ack: got %b expected 10", a); end
    checks++; if (b[207:192] !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_bank12: got %h expected beef", b[207:192]); end
    checks++; if (rd !== mrd) begin errors++; $display("[TB] FAIL wr_old_rdata: got %h expected %h", rd, mrd); end
    model_access(1'b0, 6'd12, 16'h0, me, mrd);
    do_txn(1, 1'b0, 6'd12, 16'h0, lat, a, e, rd, b);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_rdata: got %h expected beef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("[TB] FAIL rd_err: got %b expected 0", e); end
  endtask

  task automatic test_ro_reject();
    int lat; logic [NREQ-1:0] a; logic e, me; logic [15:0] rd, mrd; logic [64*16-1:0] b;
    model_access(1'b1, 6'd3, 16'h1234, me, mrd);
    do_txn(0, 1'b1, 6'd3, 16'h1234, lat, a, e, rd, b);
    mLast = 0;
    checks++; if (a !== 2'b01) begin errors++; $display("[TB] FAIL ro_ack: got %b expected 01", a); end
    checks++; if (e !== 1'b1) begin errors++; $display("[TB] FAIL ro_err: got %b expected 1", e); end
    checks++; if (rd !== RV) begin errors++; $display("[TB] FAIL ro_rdata: got %h expected %h", rd, RV); end
    checks++; if (bank_data[63:48] !== RV) begin errors++; $display("[TB] FAIL ro_bank3: got %h expected %h", bank_data[63:48], RV); end
  endtask

  task automatic test_input_change();
    logic me; logic [15:0] mrd, old10;
    old10 = mBank[10];
    model_access(1'b1, 6'd9, 16'h5555, me, mrd);
    req = '0; req[1] = 1'b1; we[1] = 1'b1; addr[11:6] = 6'd9; wdata[31:16] = 16'h5555;
    @(posedge clk); #1;
    addr[11:6] = 6'd10; wdata[31:16] = 16'h1111; we[1] = 1'b0;
    @(posedge clk); #1;
    mLast = 1;
    checks++; if (ack !== 2'b10) begin errors++; $display("[TB] FAIL chg_ack: got %b expected 10", ack); end
    checks++; if (bank_data[159:144] !== 16'h5555) begin errors++; $display("[TB] FAIL chg_bank9: got %h expected 5555", bank_data[159:144]); end
    checks++; if (bank_data[175:160] !== old10) begin errors++; $display("[TB] FAIL chg_bank10: got %h expected %h", bank_data[175:160], old10); end
    req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, r, bad; bit w; logic [5:0] ad; logic [15:0] d, rd, mrd;
    logic [NREQ-1:0] a, expAck; logic e, me; logic [64*16-1:0] b;
    for (int t = 0; t < 24; t++) begin
      r  = $urandom_range(0, NREQ - 1);
      w  = 1'($urandom_range(0, 1));
      ad = 6'($urandom_range(0, 15));
      d  = 16'($urandom);
      model_access(w, ad, d, me, mrd);
      do_txn(r, w, ad, d, lat, a, e, rd, b);
      mLast = r;
      expAck = '0; expAck[r] = 1'b1;
      checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL rnd_latency #%0d: got %0d expected 2", t, lat); end
      checks++; if (a !== expAck) begin errors++; $display("[TB] FAIL rnd_ack #%0d: got %b expected %b", t, a, expAck); end
      checks++; if (e !== me) begin errors++; $display("[TB] FAIL rnd_err #%0d: got %b expected %b", t, e, me); end
      checks++; if (rd !== mrd) begin errors++; $display("[TB] FAIL rnd_rdata #%0d: got %h expected %h", t, rd, mrd); end
      bad = -1;
      for (int i = 63; i >= 0; i--) if (b[16*i +: 16] !== mBank[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("[TB] FAIL rnd_bank #%0d: reg %0d got %h expected %h", t, bad, b[16*bad +: 16], mBank[bad]);
      end
    end
  endtask

  // Both requesters stay asserted from reset; each drops req when acked and
  // re-raises it with a fresh random access in the following IDLE cycle.
  task automatic test_contention();
    int cyc, prevCyc, expW, found;
    logic [NREQ-1:0] prevAck, expAck;
    logic me; logic [15:0] mrd;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      we[i] = 1'($urandom_range(0, 1));
      addr[6*i +: 6] = 6'($urandom_range(16, 31));
      wdata[16*i +: 16] = 16'($urandom);
    end
    req = '1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc = 0; prevCyc = 0; prevAck = '0;
    for (int t = 0; t < 6; t++) begin
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1; cyc++;
        if (ack != '0) begin found = 1; break; end
      end
      checks++; if (found == 0) begin errors++; $display("[TB] FAIL cont_timeout #%0d: got no ack expected ack", t); end
      expW = model_pick(req);
      expAck = '0; expAck[expW] = 1'b1;
      model_access(we[expW], addr[6*expW +: 6], wdata[16*expW +: 16], me, mrd);
      mLast = expW;
      checks++; if (ack !== expAck) begin errors++; $display("[TB] FAIL cont_order #%0d: got %b expected %b", t, ack, expAck); end
      checks++; if (err !== me) begin errors++; $display("[TB] FAIL cont_err #%0d: got %b expected %b", t, err, me); end
      checks++; if (rdata !== mrd) begin errors++; $display("[TB] FAIL cont_rdata #%0d: got %h expected %h", t, rdata, mrd); end
      if (t > 0) begin
        checks++; if (cyc - prevCyc !== 3) begin errors++; $display("[TB] FAIL cont_spacing #%0d: got %0d expected 3", t, cyc - prevCyc); end
        checks++; if (ack === prevAck) begin errors++; $display("[TB] FAIL cont_repeat #%0d: got %b twice expected alternation", t, ack); end
      end
      prevCyc = cyc; prevAck = ack;
      if (t == 5) begin
        req = '0;
        @(posedge clk); #1; cyc++;
      end else begin
        req[expW] = 1'b0;
        @(posedge clk); #1; cyc++;
        we[expW] = 1'($urandom_range(0, 1));
        addr[6*expW +: 6] = 6'($urandom_range(16, 31));
        wdata[16*expW +: 16] = 16'($urandom);
        req[expW] = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid();
    int found;
    req = '0; req[0] = 1'b1; we[0] = 1'b1; addr[5:0] = 6'd7; wdata[15:0] = 16'hAAAA;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_busy_grant: got %b expected 1", busy); end
    rst_n = 1'b0; req = '0;
    @(posedge clk); #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("[TB] FAIL mid_ack: got %b expected 00", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_state_idle: busy %b expected 0", busy); end
    checks++; if (bank_data[127:112] !== RV) begin errors++; $display("[TB] FAIL mid_bank7: got %h expected %h", bank_data[127:112], RV); end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++; if (ack !== 2'b00) begin errors++; $display("[TB] FAIL mid_no_late_ack: got %b expected 00", ack); end
    we = '0; addr = {6'd1, 6'd0}; req = 2'b11;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack != '0) begin found = 1; break; end
    end
    checks++; if (found == 0 || ack !== 2'b01) begin errors++; $display("[TB] FAIL mid_priority: got %b expected 01", ack); end
    req = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_ro_reject();
    test_input_change();
    test_random();
    test_contention();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
